// File: rtl/audio_mem_pkg.sv
// Shared defaults, FSM encoding and write-enable constants for the audio memory scheduler.
package audio_mem_pkg;
  localparam int MEM_WORDS_DEF = 937;
  localparam int ADDR_W_DEF    = 10;

  localparam logic [3:0] WE_ALL  = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;

  typedef enum logic [2:0] {
    IDLE,
    REC,
    PLAY_WAIT,
    PLAY_RD,
    PLAY_CAP
  } state_t;
endpackage

// File: rtl/word_ptr_counter.sv
// Clearable, incrementing word pointer with a terminal-count flag against a runtime limit.
// Clear wins over increment; the flag is combinational from the current count.
module word_ptr_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_limit);
endmodule

// File: rtl/audio_mem_scheduler.sv
// Records mic words into a shared BRAM and plays them back; play_word_valid follows play_word_req by 3 cycles.
// Define AUDIO_LOOP_PLAYBACK_EN to wrap playback to word 0 instead of stopping after the last word.
module audio_mem_scheduler
  import audio_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              mic_word_valid,
  input  logic [31:0]       mic_word,
  input  logic              play_word_req,
  input  logic [31:0]       bram_dout,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [3:0]        bram_we,
  output logic [31:0]       bram_din,
  output logic [31:0]       play_word,
  output logic              play_word_valid,
  output logic              rec_busy,
  output logic              play_busy,
  output logic [ADDR_W-1:0] rec_len
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [3:0]        r_bram_we;
  logic [31:0]       r_bram_din;
  logic [31:0]       r_play_word;
  logic              r_play_word_valid;
  logic              r_rec_busy;
  logic              r_play_busy;
  logic [ADDR_W-1:0] r_rec_len;

  logic [ADDR_W-1:0] w_wr_ptr, w_rd_ptr, w_rd_limit;
  logic              w_wr_tc, w_rd_tc;
  logic              w_wr_clr, w_wr_inc, w_rd_clr, w_rd_inc;
  logic              w_play_start, w_deliver;

  assign w_play_start = (r_state == IDLE) && !rec_btn && play_btn && (r_rec_len != '0);
  assign w_deliver    = (r_state == PLAY_CAP) && !play_btn;
  assign w_wr_clr     = (r_state == IDLE) && rec_btn;
  assign w_wr_inc     = (r_state == REC) && mic_word_valid && !w_wr_tc;
`ifdef AUDIO_LOOP_PLAYBACK_EN
  assign w_rd_clr     = w_play_start || (w_deliver && w_rd_tc);
`else
  assign w_rd_clr     = w_play_start;
`endif
  assign w_rd_inc     = w_deliver && !w_rd_tc;
  assign w_rd_limit   = r_rec_len - ADDR_W'(1);

  // Write pointer stops at the last BRAM word so it can never wrap.
  word_ptr_counter #(.W(ADDR_W)) u_wr_ptr (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_wr_clr),
    .i_inc   (w_wr_inc),
    .i_limit (ADDR_W'(MEM_WORDS - 1)),
    .o_cnt   (w_wr_ptr),
    .o_tc    (w_wr_tc)
  );

  word_ptr_counter #(.W(ADDR_W)) u_rd_ptr (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_rd_clr),
    .i_inc   (w_rd_inc),
    .i_limit (w_rd_limit),
    .o_cnt   (w_rd_ptr),
    .o_tc    (w_rd_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= IDLE;
      r_bram_addr       <= '0;
      r_bram_we         <= WE_NONE;
      r_bram_din        <= '0;
      r_play_word       <= '0;
      r_play_word_valid <= 1'b0;
      r_rec_busy        <= 1'b0;
      r_play_busy       <= 1'b0;
      r_rec_len         <= '0;
    end else begin
      r_bram_we         <= WE_NONE;
      r_play_word_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rec_btn) begin
            r_state    <= REC;
            r_rec_busy <= 1'b1;
          end else if (w_play_start) begin
            r_state     <= PLAY_WAIT;
            r_play_busy <= 1'b1;
          end
        end
        REC: begin
          if (mic_word_valid) begin
            r_bram_we   <= WE_ALL;
            r_bram_din  <= mic_word;
            r_bram_addr <= w_wr_ptr;
          end
          // A word arriving with the stop request still counts toward the length.
          if (rec_btn || (mic_word_valid && w_wr_tc)) begin
            r_rec_len  <= w_wr_ptr + ADDR_W'(mic_word_valid);
            r_state    <= IDLE;
            r_rec_busy <= 1'b0;
          end
        end
        PLAY_WAIT: begin
          if (play_btn) begin
            r_state     <= IDLE;
            r_play_busy <= 1'b0;
          end else if (play_word_req) begin
            r_state     <= PLAY_RD;
            r_bram_addr <= w_rd_ptr;
          end
        end
        PLAY_RD: begin
          if (play_btn) begin
            r_state     <= IDLE;
            r_play_busy <= 1'b0;
          end else begin
            r_state <= PLAY_CAP;
          end
        end
        PLAY_CAP: begin
          if (play_btn) begin
            r_state     <= IDLE;
            r_play_busy <= 1'b0;
          end else begin
            r_play_word       <= bram_dout;
            r_play_word_valid <= 1'b1;
`ifdef AUDIO_LOOP_PLAYBACK_EN
            r_state <= PLAY_WAIT;
`else
            if (w_rd_tc) begin
              r_state     <= IDLE;
              r_play_busy <= 1'b0;
            end else begin
              r_state <= PLAY_WAIT;
            end
`endif
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rec_busy  <= 1'b0;
          r_play_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bram_addr       = r_bram_addr;
  assign bram_we         = r_bram_we;
  assign bram_din        = r_bram_din;
  assign play_word       = r_play_word;
  assign play_word_valid = r_play_word_valid;
  assign rec_busy        = r_rec_busy;
  assign play_busy       = r_play_busy;
  assign rec_len         = r_rec_len;
endmodule
